dist_job_sequencer: RTL and testbench

//  Upstream/downstream wrapper around the min/max-distance core (top). Streams 64 operand bytes

---
 rtl/dist_seq_pkg.sv | 24 ++
 rtl/dist_seq_watchdog.sv | 27 ++
 rtl/dist_job_sequencer.sv | 146 ++++++++++++++
 tb/tb_dist_job_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dist_seq_pkg.sv
// rtl/dist_seq_pkg.sv - shared states and address constants for the job sequencer
package dist_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRESET,
    LAUNCH,
    RUN,
    READ,
    REPORT
  } state_t;

  // Result bytes live big-endian at MIN_ADDR..MIN_ADDR+3 (min MSB, min LSB, max MSB, max LSB)
  localparam logic [7:0] MIN_ADDR     = 8'd66;
  localparam logic [7:0] MIN_LSB_ADDR = MIN_ADDR + 8'd1;
  localparam logic [7:0] MAX_ADDR     = MIN_ADDR + 8'd2;
  localparam logic [7:0] READ_LAST    = MAX_ADDR + 8'd1;
  localparam logic [7:0] CLR_END      = 8'd255;
  localparam logic [7:0] PRESET_MIN   = 8'hFF;
  localparam logic [7:0] PRESET_CLR   = 8'h00;
  localparam int         DONE_BLANK   = 2;

endpackage

// File: rtl/dist_seq_watchdog.sv
// rtl/dist_seq_watchdog.sv - run-cycle counter with terminal-count flag
// Ports: clk, reset (sync, active-high), clear (zero count), enable (count this cycle),
//        count (cycles counted so far), expired (this enabled cycle is the TIMEOUT-th)
module dist_seq_watchdog #(
  parameter int TIMEOUT = 65535,
  localparam int W = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != W'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of earlier enabled cycles, so the flag marks the TIMEOUT-th one
  assign expired = enable && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/dist_job_sequencer.sv
// rtl/dist_job_sequencer.sv - loads operands, presets results, runs the distance core, returns min/max
// Ports: clk, reset (sync, active-high); in_valid/in_data/in_ready operand byte stream;
//        dm_own/dm_addr/dm_wr_en/dm_wr_data/dm_rd_data data_mem port (dm_own=1: sequencer owns);
//        core_start (1 = hold, 0 = run), core_done; res_valid/res_min/res_max/res_err/res_ready
//        result handshake; busy (not idle)
module dist_job_sequencer
  import dist_seq_pkg::*;
#(
  parameter int N_BYTES = 64,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dm_own,
  output logic [7:0]  dm_addr,
  output logic        dm_wr_en,
  output logic [7:0]  dm_wr_data,
  input  logic [7:0]  dm_rd_data,
  output logic        core_start,
  input  logic        core_done,
  output logic        res_valid,
  output logic [15:0] res_min,
  output logic [15:0] res_max,
  output logic        res_err,
  input  logic        res_ready,
  output logic        busy
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [7:0]        idx;
  logic              accept;
  logic              done_ok;
  logic              wd_expired;
  logic [WD_W-1:0]   run_cnt;

  dist_seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != RUN),
    .enable  (state == RUN),
    .count   (run_cnt),
    .expired (wd_expired)
  );

  assign in_ready  = !reset && ((state == IDLE) || (state == LOAD));
  assign accept    = in_ready && in_valid;
  // The first RUN cycles may still see done left over from the previous job
  assign done_ok   = core_done && (run_cnt >= WD_W'(DONE_BLANK));
  assign res_valid = (state == REPORT);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    dm_addr    = idx;
    dm_wr_en   = 1'b0;
    dm_wr_data = in_data;
    case (state)
      IDLE: begin
        dm_addr  = 8'd0;
        dm_wr_en = accept;
        if (accept) state_n = LOAD;
      end
      LOAD: begin
        dm_wr_en = accept;
        if (accept && (idx == 8'(N_BYTES - 1))) state_n = PRESET;
      end
      PRESET: begin
        dm_wr_en   = 1'b1;
        dm_wr_data = (idx <= MIN_LSB_ADDR) ? PRESET_MIN : PRESET_CLR;
        if (idx == CLR_END) state_n = LAUNCH;
      end
      LAUNCH: state_n = RUN;
      RUN: begin
        if (done_ok)         state_n = READ;
        else if (wd_expired) state_n = REPORT;
      end
      READ: begin
        if (idx == READ_LAST) state_n = REPORT;
      end
      REPORT: begin
        if (res_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // A reset cycle must never disturb memory, whatever state it interrupts
    if (reset) dm_wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 8'd0;
      core_start <= 1'b1;
      dm_own     <= 1'b1;
      res_min    <= 16'hFFFF;
      res_max    <= 16'h0000;
      res_err    <= 1'b0;
    end else begin
      state      <= state_n;
      // Registered from next state so the core sees start/ownership one cycle after LAUNCH
      core_start <= (state_n != RUN);
      dm_own     <= (state_n != RUN);
      case (state)
        IDLE: begin
          if (accept) idx <= 8'd1;
        end
        LOAD: begin
          if (accept) begin
            // dm[64:65] belong to the core, so the preset pass starts at the result bytes
            if (idx == 8'(N_BYTES - 1)) idx <= MIN_ADDR;
            else                        idx <= idx + 8'd1;
          end
        end
        PRESET: begin
          if (idx != CLR_END) idx <= idx + 8'd1;
        end
        LAUNCH: begin
          idx     <= MIN_ADDR;
          res_min <= 16'hFFFF;
          res_max <= 16'h0000;
          res_err <= 1'b0;
        end
        RUN: begin
          if (!done_ok && wd_expired) res_err <= 1'b1;
        end
        READ: begin
          if (idx == MIN_ADDR)          res_min[15:8] <= dm_rd_data;
          else if (idx == MIN_LSB_ADDR) res_min[7:0]  <= dm_rd_data;
          else if (idx == MAX_ADDR)     res_max[15:8] <= dm_rd_data;
          else                          res_max[7:0]  <= dm_rd_data;
          idx <= idx + 8'd1;
        end
        REPORT: begin
          if (res_ready) idx <= 8'd0;
        end
        default: idx <= 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_job_sequencer.sv
// tb/tb_dist_job_sequencer.sv - self-checking bench for dist_job_sequencer with memory and core models
module tb_dist_job_sequencer;

  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        dm_own;
  logic [7:0]  dm_addr;
  logic        dm_wr_en;
  logic [7:0]  dm_wr_data;
  logic [7:0]  dm_rd_data;
  logic        core_start;
  logic        core_done;
  logic        res_valid;
  logic [15:0] res_min;
  logic [15:0] res_max;
  logic        res_err;
  logic        res_ready;
  logic        busy;

  logic [7:0]  mem [256];
  logic        core_we;
  logic [15:0] core_min, core_max;
  logic        sent_we;
  logic [15:0] sent_val;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dist_job_sequencer #(.N_BYTES(64), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .dm_own     (dm_own),
    .dm_addr    (dm_addr),
    .dm_wr_en   (dm_wr_en),
    .dm_wr_data (dm_wr_data),
    .dm_rd_data (dm_rd_data),
    .core_start (core_start),
    .core_done  (core_done),
    .res_valid  (res_valid),
    .res_min    (res_min),
    .res_max    (res_max),
    .res_err    (res_err),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  // data_mem model: sequencer port when it owns memory, core result writes otherwise
  assign dm_rd_data = mem[dm_addr];
  always @(posedge clk) begin
    if (dm_own && dm_wr_en) mem[dm_addr] <= dm_wr_data;
    if (!dm_own && core_we) begin
      mem[66] <= core_min[15:8];
      mem[67] <= core_min[7:0];
      mem[68] <= core_max[15:8];
      mem[69] <= core_max[7:0];
    end
    if (sent_we) begin
      mem[64] <= sent_val[15:8];
      mem[65] <= sent_val[7:0];
    end
  end

  typedef struct {
    int          gap_every;  // 0 none, >0 gap after every N bytes, <0 random gaps
    int          gap_len;
    int          done_at;    // RUN cycle with done=1, 0 = never
    bit          stale;      // done held during LOAD and in RUN cycle 1
    bit          fixed;      // use the signed-word pattern instead of random bytes
    logic [15:0] cmin, cmax; // what the core model writes
    int          stall;      // REPORT cycles with res_ready=0
  } vec_t;

  vec_t vecs[5];
  logic [7:0] bytes [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Streams bytes[] with the given gap pattern; returns at the negedge after the last accept
  task automatic load_bytes(input int gap_every, input int gap_len);
    int i = 0;
    int gap = 0;
    int guard = 0;
    while (i < 64 && guard < 3000) begin
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        in_data  = bytes[i];
        #1;
        if (in_ready) begin
          i++;
          if (gap_every > 0 && (i % gap_every) == 0) gap = gap_len;
          else if (gap_every < 0) gap = $urandom_range(0, 2);
        end
      end
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    check("load_complete", i, 64);
  endtask

  task automatic run_job(input vec_t v);
    int lat;
    int r;
    int errs;
    int unstable;
    bit exp_err;
    logic [15:0] w, hold_min, hold_max;
    for (int k = 0; k < 32; k++) begin
      w = (k == 0) ? 16'd0 : (k == 1) ? 16'd100 : (k == 2) ? 16'hFF9C :
          (k == 3) ? 16'h7FFF : (k == 4) ? 16'h8000 : 16'd5;
      bytes[2*k]   = v.fixed ? w[15:8] : 8'($urandom);
      bytes[2*k+1] = v.fixed ? w[7:0]  : 8'($urandom);
    end
    @(negedge clk);
    sent_we  = 1'b1;
    sent_val = 16'($urandom);
    @(negedge clk);
    sent_we   = 1'b0;
    core_done = v.stale;
    load_bytes(v.gap_every, v.gap_len);
    core_done = 1'b0;

    // 192 cycles from the last accepted byte to the first RUN cycle
    lat = 1;
    while (core_start !== 1'b0 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("launch_latency", lat, 192);
    check("run_dm_own", dm_own, 0);

    errs = 0;
    for (int a = 0; a < 64; a++) if (mem[a] !== bytes[a]) errs++;
    check("image_operands", errs, 0);
    check("image_scratch", {mem[64], mem[65]}, sent_val);
    errs = 0;
    for (int a = 66; a < 256; a++) if (mem[a] !== ((a < 68) ? 8'hFF : 8'h00)) errs++;
    check("image_preset", errs, 0);

    // Core model: writes its results in RUN cycle 1, raises done only in the chosen cycle
    r = 1;
    while (!res_valid && r < TMO + 20) begin
      core_we   = (r == 1);
      core_min  = v.cmin;
      core_max  = v.cmax;
      core_done = (r == v.done_at) || (v.stale && r == 1);
      @(negedge clk);
      r++;
    end
    core_we   = 1'b0;
    core_done = 1'b0;
    exp_err = (v.done_at < 3);
    check("report_cycle", r, exp_err ? TMO + 1 : v.done_at + 5);
    check("res_err", res_err, exp_err);
    check("res_min", res_min, exp_err ? 16'hFFFF : v.cmin);
    check("res_max", res_max, exp_err ? 16'h0000 : v.cmax);
    check("report_core_start", core_start, 1);
    check("report_dm_own", dm_own, 1);

    // Hold off the consumer while a byte is offered; nothing may change or be taken
    hold_min = res_min;
    hold_max = res_max;
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = ~bytes[0];
    unstable  = 0;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (!res_valid || res_min !== hold_min || res_max !== hold_max || in_ready) unstable++;
    end
    check("stall_stable", unstable, 0);
    res_ready = 1'b1;
    #1;
    check("report_in_ready", in_ready, 0);
    @(negedge clk);
    res_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    check("idle_res_valid", res_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 1);
    check("byte_not_taken", mem[0], bytes[0]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{gap_every: 0,  gap_len: 0, done_at: 5, stale: 1, fixed: 1,
                cmin: 16'h0000, cmax: 16'hFFFF, stall: 0};
    vecs[1] = '{gap_every: 8,  gap_len: 3, done_at: 9, stale: 0, fixed: 0,
                cmin: 16'($urandom), cmax: 16'($urandom), stall: 2};
    vecs[2] = '{gap_every: -1, gap_len: 0, done_at: 0, stale: 1, fixed: 0,
                cmin: 16'h1234, cmax: 16'h5678, stall: 3};
    vecs[3] = '{gap_every: 0,  gap_len: 0, done_at: 2, stale: 1, fixed: 0,
                cmin: 16'h0101, cmax: 16'h0202, stall: 0};
    vecs[4] = '{gap_every: -1, gap_len: 0, done_at: 3, stale: 0, fixed: 0,
                cmin: 16'($urandom), cmax: 16'($urandom), stall: 10};

    reset = 1'b1; in_valid = 1'b1; in_data = 8'h3C; core_done = 1'b0;
    res_ready = 1'b0; core_we = 1'b0; core_min = '0; core_max = '0;
    sent_we = 1'b0; sent_val = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 0);
    check("reset_wr_en", dm_wr_en, 0);
    in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_core_start", core_start, 1);
    check("rst_dm_own", dm_own, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_min", res_min, 16'hFFFF);
    check("rst_res_max", res_max, 16'h0000);
    check("rst_res_err", res_err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    for (int v = 0; v < 5; v++) begin
      if (v == 4) begin
        // Abort a job partway through the preset pass
        for (int a = 0; a < 64; a++) bytes[a] = 8'($urandom);
        @(negedge clk);
        load_bytes(0, 0);
        repeat (50) @(negedge clk);
        check("mid_preset_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_reset_wr_en", dm_wr_en, 0);
        check("mid_reset_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_core_start", core_start, 1);
        check("abort_in_ready", in_ready, 1);
        check("abort_res_valid", res_valid, 0);
      end
      run_job(vecs[v]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
